// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - 2x2 pixel frame capture into a 4-entry FIFO with ready/valid readout
// Optional feature macro: PIXEL_READOUT_CHECKSUM_EN adds o_frame_sum (mod-256 sum of delivered pixels).
module pixel_readout (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_adc,
    input  logic       i_nre_1,
    input  logic       i_nre_2,
    input  logic [7:0] i_adc_data,
    input  logic       i_pix_ready,
    output logic       o_pix_valid,
    output logic [7:0] o_pix_data,
    output logic       o_pix_row,
    output logic       o_pix_col,
    output logic       o_frame_done,
`ifdef PIXEL_READOUT_CHECKSUM_EN
    output logic [7:0] o_frame_sum,
`endif
    output logic       o_err
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_adc_d;
    logic [1:0] r_cnt0;
    logic [1:0] r_cnt1;
    logic [9:0] r_mem [4];
    logic [1:0] r_rd;
    logic [1:0] r_wr;
    logic [2:0] r_count;
    logic       r_err;

    logic       w_rise;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_row;
    logic [1:0] w_row_cnt;
    logic       w_cap_req;
    logic       w_row_ovf;
    logic       w_both;
    logic       w_push;
    logic       w_drop;
    logic       w_start;
    logic       w_err_set;
    logic [9:0] w_head;

    assign w_rise    = i_adc & ~r_adc_d;
    assign w_empty   = (r_count == 3'd0);
    assign w_full    = (r_count == 3'd4);
    assign w_pop     = ~w_empty & i_pix_ready;
    // Row 1 is selected when NRE_2 is the one pulled low.
    assign w_row     = i_nre_1;
    assign w_row_cnt = w_row ? r_cnt1 : r_cnt0;
    assign w_cap_req = (r_state == S_CAPTURE) & i_adc & (i_nre_1 ^ i_nre_2);
    assign w_row_ovf = w_cap_req & (w_row_cnt == 2'd2);
    assign w_both    = (r_state == S_CAPTURE) & i_adc & ~i_nre_1 & ~i_nre_2;
    assign w_push    = w_cap_req & ~w_row_ovf & (~w_full | w_pop);
    assign w_drop    = w_cap_req & ~w_row_ovf & w_full & ~w_pop;
    assign w_start   = (r_state == S_IDLE) & w_rise;
    assign w_err_set = w_row_ovf | w_drop | w_both |
                       (w_rise & ((r_state == S_DRAIN) | (r_state == S_DONE)));
    assign w_head    = r_mem[r_rd];

    always_comb begin
        w_state_nxt  = r_state;
        o_frame_done = 1'b0;
        o_pix_valid  = ~w_empty;
        o_pix_data   = 8'd0;
        o_pix_row    = 1'b0;
        o_pix_col    = 1'b0;
        if (!w_empty) begin
            o_pix_data = w_head[7:0];
            o_pix_col  = w_head[8];
            o_pix_row  = w_head[9];
        end
        case (r_state)
            S_IDLE:    if (w_rise) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (!i_adc) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_empty) w_state_nxt = S_DONE;
            S_DONE: begin
                o_frame_done = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_adc_d <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_adc_d <= i_adc;
            if (w_start)
                r_err <= 1'b0;
            else if (w_err_set)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || w_start) begin
            r_cnt0 <= 2'd0;
            r_cnt1 <= 2'd0;
        end else if (w_push) begin
            if (w_row)
                r_cnt1 <= r_cnt1 + 2'd1;
            else
                r_cnt0 <= r_cnt0 + 2'd1;
        end
    end

    // Entry layout: {row, col, data}
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < 4; i++)
                r_mem[i] <= 10'd0;
            r_rd    <= 2'd0;
            r_wr    <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {w_row, w_row_cnt[0], i_adc_data};
                r_wr        <= r_wr + 2'd1;
            end
            if (w_pop)
                r_rd <= r_rd + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_err = r_err;

`ifdef PIXEL_READOUT_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (!i_reset || w_start)
            r_sum <= 8'd0;
        else if (w_pop)
            r_sum <= r_sum + o_pix_data;
    end

    assign o_frame_sum = r_sum;
`endif

endmodule
